multi_clk_divider: RTL and testbench
====================================

// Module: multi_clk_divider
// PURPOSE
//  Parametrised N-channel clock divider/enable generator fed by clk_100MHz.
//  Each channel has a runtime-programmable divisor, a registered divided clock and a one-cycle tick.
//  Divisor changes are shadowed and applied only at a period boundary (glitch-free).
//  Feeds pipeline-stage enables, UART/display timebases and slow peripheral clocks.
// PARAMETERS
//  N_CH        4   number of independent divider channels (1..16)
//  DIV_W       16  divisor / counter width in bits
//  DEFAULT_DIV 2   active divisor of every channel after reset (2 = 50 MHz from 100 MHz)
// PORTS
//  clk_100MHz  in   1            sole clock, all logic rising-edge
//  rst_n       in   1            asynchronous assert, active-low reset
//  div_wr      in   N_CH         per-channel divisor write strobe (one cycle)
//  div_wdata   in   DIV_W        divisor value, shared by all channels
//  div_pend    out  N_CH         1 = written divisor waiting for period boundary
//  clk_div     out  N_CH         divided clock per channel, registered
//  tick        out  N_CH         one-cycle pulse at end of each channel period
//  sync_start  in   1            present only with MCD_SYNC_START_EN
// BEHAVIOUR
//  Reset (rst_n=0, asynchronous): cnt=0; active div=DEFAULT_DIV; shadow=0; div_pend=0; clk_div=0; tick=0.
//  Per channel, active divisor D, HIGH=ceil(D/2):
//  - D>=2: cnt runs 0..D-1 and wraps. clk_div=(cnt<HIGH) and tick=(cnt==D-1).
//    Both outputs are registered, so they lag cnt by exactly 1 cycle.
//    Period is D cycles. Even D gives 50% duty. Odd D: high HIGH cycles, low D-HIGH cycles.
//  - D==1: tick=1 every cycle; clk_div held 0.
//  - D==0: channel stopped; cnt held 0; clk_div=0; tick=0.
//  Write (div_wr[i]=1):
//  - shadow<=div_wdata and div_pend[i]<=1 on the next edge.
//  - Apply: if div_pend and (cnt==D-1 or D<=1), then active D<=shadow, cnt<=0, div_pend<=0 on the same edge.
//  - A new period starts immediately with the new D; clk_div never shortens a high or low phase.
//  - Write while pending overwrites shadow; only the last value is applied; div_pend stays 1.
//  - Write in the same cycle as the apply edge: the old shadow is applied; the new value is captured and div_pend stays 1.
//  - Writing D==0 stops the channel at the end of the current period, leaving clk_div low.
//  - Writing to a stopped channel applies on the cycle after the write.
//  - Channels are fully independent; multiple div_wr bits may be set in one cycle.
//  - Mid-operation reset: all channels return to reset values immediately (async); restart from cnt=0 after release.
//  - Counter arithmetic is unsigned DIV_W bits; wrap uses compare to D-1, not overflow.
// CONFIGURATION
//  MCD_SYNC_START_EN defined:
//  - Adds port sync_start.
//  - A one-cycle pulse forces every channel with D>=1 to cnt=0 on the next edge, phase-aligning all outputs.
//  - A pending divisor on any channel is applied at the same edge.
//  - sync_start has priority over the normal wrap/apply.
//  MCD_SYNC_START_EN undefined: no port; channel phases depend only on reset release and write history.
// STRUCTURE
//  Package mcd_pkg:
//  - MCD_MAX_CH=16
//  - function half_ceil(D) returning ceil(D/2)
//  - typedef div_t = logic [DIV_W-1:0] via parameterised localparam pattern
//  Sub-module mcd_channel: counter, active/shadow divisor, pending flag, output registers.
//  - Top is a generate loop over N_CH instances plus the optional sync fan-out.
// TESTING
//  1. Reset, defaults, N_CH=4: every clk_div toggles every cycle (50 MHz); tick every 2nd cycle, first tick 2 cycles after release.
//  2. ch0 write 5: div_pend[0]=1 until old period ends; then clk_div[0] is 3 high/2 low; tick[0] every 5 cycles; div_pend[0]=0.
//  3. ch1 writes 10 then 4 on consecutive cycles: only 4 takes effect; period 4 (2 high/2 low); no intermediate period of 10.
//  4. ch2 write 0: output low after the current period completes; tick[2]=0. Then write 1: tick[2]=1 every cycle from 2 cycles after the write.
//  5. Assert rst_n=0 mid-period on D=7 channel: clk_div/tick drop to 0 immediately; after release, D=DEFAULT_DIV (2), not 7.
//  6. (MCD_SYNC_START_EN) ch0 D=3, ch1 D=6 at arbitrary phases; pulse sync_start: both ticks coincide 3 and 6 cycles later, then every 6 cycles.

Source files
------------

// File: rtl/mcd_pkg.sv
// mcd_pkg: shared constants, divisor type and half-period helper for multi_clk_divider
package mcd_pkg;
  localparam int MCD_MAX_CH = 16;
  localparam int MCD_DIV_W  = 16;
  typedef logic [MCD_DIV_W-1:0] div_t;
  function automatic logic [31:0] half_ceil(input logic [31:0] d);
    return (d >> 1) + {31'd0, d[0]};
  endfunction
endpackage

// File: rtl/mcd_channel.sv
// mcd_channel: one divider channel with shadowed divisor applied at period boundary
module mcd_channel
  import mcd_pkg::*;
#(
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk_100MHz,
  input  logic             rst_n,
  input  logic             wr,
  input  logic [DIV_W-1:0] wdata,
  input  logic             sync,
  output logic             pend,
  output logic             clk_div,
  output logic             tick
);
  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);
  logic [DIV_W-1:0] cnt_q, cnt_d, div_q, div_d, shadow_q, shadow_d, high;
  logic pend_q, pend_d, clk_q, clk_d, tick_q, tick_d, last, apply;
  // next counter, divisor swap and registered outputs derived from the current period position
  always_comb begin
    high     = DIV_W'(half_ceil(32'(div_q)));
    last     = (div_q != '0) && (cnt_q == div_q - ONE);
    apply    = pend_q && (sync || last || div_q <= ONE);
    shadow_d = wr ? wdata : shadow_q;
    pend_d   = wr || (pend_q && !apply);
    div_d    = apply ? shadow_q : div_q;
    cnt_d    = (apply || sync || last || div_q == '0) ? '0 : cnt_q + ONE;
    clk_d    = (div_q > ONE) && (cnt_q < high);
    tick_d   = last;
  end
  // state and output registers
  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      div_q    <= DIV_W'(DEFAULT_DIV);
      shadow_q <= '0;
      pend_q   <= 1'b0;
      clk_q    <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      clk_q    <= clk_d;
      tick_q   <= tick_d;
    end
  end
  assign pend    = pend_q;
  assign clk_div = clk_q;
  assign tick    = tick_q;
endmodule

// File: rtl/multi_clk_divider.sv
// multi_clk_divider: N-channel clock divider/tick generator; MCD_SYNC_START_EN adds sync_start phase alignment
module multi_clk_divider
  import mcd_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk_100MHz,
  input  logic             rst_n,
`ifdef MCD_SYNC_START_EN
  input  logic             sync_start,
`endif
  input  logic [N_CH-1:0]  div_wr,
  input  logic [DIV_W-1:0] div_wdata,
  output logic [N_CH-1:0]  div_pend,
  output logic [N_CH-1:0]  clk_div,
  output logic [N_CH-1:0]  tick
);
  logic sync;
`ifdef MCD_SYNC_START_EN
  assign sync = sync_start;
`else
  assign sync = 1'b0;
`endif
  if (N_CH < 1 || N_CH > MCD_MAX_CH) begin : g_bad_n_ch
    $error("N_CH out of range");
  end
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    mcd_channel #(.DIV_W(DIV_W), .DEFAULT_DIV(DEFAULT_DIV)) u_ch (
      .clk_100MHz(clk_100MHz),
      .rst_n     (rst_n),
      .wr        (div_wr[i]),
      .wdata     (div_wdata),
      .sync      (sync),
      .pend      (div_pend[i]),
      .clk_div   (clk_div[i]),
      .tick      (tick[i])
    );
  end
endmodule

// File: tb/tb_multi_clk_divider.sv
// tb_multi_clk_divider: random and directed checks of multi_clk_divider against a period-level model
module tb_multi_clk_divider;
  localparam int N = 4;
  localparam int W = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sync_start = 1'b0;
  logic [N-1:0] div_wr = '0;
  logic [W-1:0] div_wdata = '0;
  logic [N-1:0] div_pend, clk_div, tick;
  int n_chk = 0;
  int n_pass = 0;
  bit run = 1'b0;
  int md[N] = '{default: 2};
  int msh[N] = '{default: 0};
  int mph[N] = '{default: 0};
  logic [N-1:0] mpend = '0, mclk = '0, mtick = '0;

  multi_clk_divider #(.N_CH(N), .DIV_W(W), .DEFAULT_DIV(2)) dut (
    .clk_100MHz(clk),
    .rst_n     (rst_n),
`ifdef MCD_SYNC_START_EN
    .sync_start(sync_start),
`endif
    .div_wr    (div_wr),
    .div_wdata (div_wdata),
    .div_pend  (div_pend),
    .clk_div   (clk_div),
    .tick      (tick)
  );

  always #5 clk = ~clk;

  // model: each channel is a divisor D and a phase within its current period
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        md[i] = 2; msh[i] = 0; mph[i] = 0;
      end
      mpend = '0; mclk = '0; mtick = '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        bit eop;
        eop = (md[i] <= 1) || (mph[i] == md[i] - 1);
        mclk[i] = (md[i] >= 2) && (mph[i] < (md[i] + 1) / 2);
        mtick[i] = (md[i] >= 1) && (mph[i] == md[i] - 1);
        if (mpend[i] && (sync_start || eop)) begin
          md[i] = msh[i]; mph[i] = 0; mpend[i] = 1'b0;
        end else if (sync_start || eop) mph[i] = 0;
        else mph[i] = mph[i] + 1;
        if (div_wr[i]) begin
          msh[i] = int'(div_wdata); mpend[i] = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (run) begin
      n_chk++;
      if ({div_pend, clk_div, tick} === {mpend, mclk, mtick}) n_pass++;
      else $display("FAIL model t=%0t pend/clk/tick dut=%b/%b/%b exp=%b/%b/%b",
                    $time, div_pend, clk_div, tick, mpend, mclk, mtick);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #6;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
  endtask

  task automatic wr(input logic [N-1:0] m, input int v);
    div_wr = m;
    div_wdata = W'(v);
    cyc();
    div_wr = '0;
  endtask

  task automatic meas(input int ch, output int per, output int hi);
    int g = 0;
    per = 0;
    hi = 0;
    while (!tick[ch] && g < 100) begin cyc(); g++; end
    do begin cyc(); per++; hi += int'(clk_div[ch]); end while (!tick[ch] && per < 100);
  endtask

  initial begin
    int per, hi;
    cyc();
    run = 1'b1;
    cyc();
    chk("reset_clk", 32'(clk_div), 0);
    chk("reset_tick", 32'(tick), 0);
    rst_n = 1'b1;
    cyc();
    chk("t1_first_clk", 32'(clk_div), 32'hF);
    chk("t1_first_tick", 32'(tick), 0);
    cyc();
    chk("t1_second_clk", 32'(clk_div), 0);
    chk("t1_second_tick", 32'(tick), 32'hF);
    cyc();
    chk("t1_third_clk", 32'(clk_div), 32'hF);
    wr(4'b0001, 5);
    chk("t2_pend_set", 32'(div_pend[0]), 1);
    repeat (4) cyc();
    chk("t2_pend_clr", 32'(div_pend[0]), 0);
    meas(0, per, hi);
    chk("t2_period", per, 5);
    chk("t2_high", hi, 3);
    while (!tick[1]) cyc();
    cyc();
    div_wr = 4'b0010; div_wdata = W'(10);
    cyc();
    div_wdata = W'(4);
    cyc();
    div_wr = '0;
    repeat (3) cyc();
    meas(1, per, hi);
    chk("t3_period", per, 4);
    chk("t3_high", hi, 2);
    meas(1, per, hi);
    chk("t3_period2", per, 4);
    wr(4'b0100, 0);
    repeat (10) cyc();
    chk("t4_stop_clk", 32'(clk_div[2]), 0);
    chk("t4_stop_tick", 32'(tick[2]), 0);
    wr(4'b0100, 1);
    cyc();
    chk("t4_apply_tick", 32'(tick[2]), 0);
    cyc();
    chk("t4_d1_tick", 32'(tick[2]), 1);
    cyc();
    chk("t4_d1_tick2", 32'(tick[2]), 1);
    chk("t4_d1_clk", 32'(clk_div[2]), 0);
    wr(4'b1000, 7);
    repeat (12) cyc();
    rst_n = 1'b0;
    #1;
    chk("t5_rst_clk", 32'(clk_div), 0);
    chk("t5_rst_tick", 32'(tick), 0);
    chk("t5_rst_pend", 32'(div_pend), 0);
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("t5_rel_clk", 32'(clk_div), 32'hF);
    cyc();
    chk("t5_rel_tick", 32'(tick), 32'hF);
    meas(3, per, hi);
    chk("t5_period", per, 2);
    repeat (1500) begin
      for (int i = 0; i < N; i++) div_wr[i] = ($urandom_range(0, 9) == 0);
      div_wdata = W'($urandom_range(0, 9));
`ifdef MCD_SYNC_START_EN
      sync_start = ($urandom_range(0, 39) == 0);
`endif
      cyc();
    end
    div_wr = '0;
    sync_start = 1'b0;
`ifdef MCD_SYNC_START_EN
    wr(4'b0001, 3);
    wr(4'b0010, 6);
    repeat ($urandom_range(3, 11)) cyc();
    sync_start = 1'b1;
    cyc();
    sync_start = 1'b0;
    repeat (3) cyc();
    chk("t6_tick3", 32'(tick[0]), 1);
    repeat (3) cyc();
    chk("t6_tick6", 32'(tick[1:0]), 3);
    repeat (6) cyc();
    chk("t6_tick12", 32'(tick[1:0]), 3);
`endif
    repeat (2) cyc();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
